// File: rtl/top_sys_if.sv
// top_sys_if: serial line pair between a host (master) and the top_sys
// register/ALU subsystem (slave).
//   S_DATA_IN_RX  : host -> subsystem serial frames, idle high
//   S_DATA_OUT_TX : subsystem -> host serial frames, idle high
interface top_sys_if;
    logic S_DATA_IN_RX;
    logic S_DATA_OUT_TX;

    modport master (output S_DATA_IN_RX, input S_DATA_OUT_TX);
    modport slave  (input S_DATA_IN_RX, output S_DATA_OUT_TX);
endinterface

// File: rtl/top_sys.sv
// top_sys: UART-controlled 16x8 register file with a 14-function ALU.
// Incoming frames (start, 8 data LSB first, even parity, stop) are decoded
// as write / read / ALU-with-operands / ALU-on-registers commands; read data
// and 16-bit ALU results (low byte first) go back through a 4-byte FIFO and
// a serial transmitter.
//   REF_CLK : system clock, rising edge
//   RST     : asynchronous active-low reset
//   ser     : serial line pair (slave side)
module top_sys #(
    parameter int DATA_WIDTH       = 8,
    parameter int NUM_OF_REGISTERS = 16,
    parameter int ADDRESS_WIDTH    = $clog2(NUM_OF_REGISTERS),
    parameter int ALU_OUT_WIDTH    = 16,
    parameter int CLKS_PER_BIT     = 16,
    parameter int TX_FIFO_DEPTH    = 4
) (
    input  logic      REF_CLK,
    input  logic      RST,
    top_sys_if.slave  ser
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int FCW   = $clog2(TX_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_ADDR  = 3'd1;
    localparam logic [2:0] S_WR_DATA  = 3'd2;
    localparam logic [2:0] S_RD_ADDR  = 3'd3;
    localparam logic [2:0] S_ALU_A    = 3'd4;
    localparam logic [2:0] S_ALU_B    = 3'd5;
    localparam logic [2:0] S_ALU_FUNC = 3'd6;

    // ---------------- RX ----------------
    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    logic                  rx_busy_q;
    logic [CNT_W-1:0]      rx_cnt_q;
    logic [3:0]            rx_bit_q;   // 0 start, 1..8 data, 9 parity, 10 stop
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_byte_q;
    logic                  rx_par_q;
    logic                  byte_valid_q, frame_err_q;

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_busy_q    <= 1'b0;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_sh_q      <= '0;
            rx_byte_q    <= '0;
            rx_par_q     <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= ser.S_DATA_IN_RX;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (!rx_busy_q) begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF_LAST;  // first sample lands mid start bit
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= BIT_LAST;
                rx_bit_q <= rx_bit_q + 1'b1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_sync_q) rx_busy_q <= 1'b0;  // start glitch
                end else if (rx_bit_q <= 4'd8) begin
                    rx_sh_q <= {rx_sync_q, rx_sh_q[DATA_WIDTH-1:1]};
                end else if (rx_bit_q == 4'd9) begin
                    rx_par_q <= rx_sync_q;
                end else begin
                    rx_busy_q <= 1'b0;
                    if (!(^rx_sh_q ^ rx_par_q) && rx_sync_q) begin
                        byte_valid_q <= 1'b1;
                        rx_byte_q    <= rx_sh_q;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- command FSM, register file, ALU ----------------
    logic [2:0]               state_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    regs_q [NUM_OF_REGISTERS];
    logic                     hi_pend_q;
    logic [DATA_WIDTH-1:0]    hi_q;
    logic [ALU_OUT_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0]    op_a, op_b;

    assign op_a = regs_q[0];
    assign op_b = regs_q[1];

    always_comb begin
        alu_res = '0;
        case (rx_byte_q[3:0])
            4'd0:  alu_res = {8'b0, op_a} + {8'b0, op_b};
            4'd1:  alu_res = {8'b0, op_a} - {8'b0, op_b};
            4'd2:  alu_res = {8'b0, op_a} * {8'b0, op_b};
            4'd3:  alu_res = (op_b == '0) ? '0 : {8'b0, op_a / op_b};
            4'd4:  alu_res = {8'b0, op_a & op_b};
            4'd5:  alu_res = {8'b0, op_a | op_b};
            4'd6:  alu_res = {8'b0, ~(op_a & op_b)};
            4'd7:  alu_res = {8'b0, ~(op_a | op_b)};
            4'd8:  alu_res = {8'b0, op_a ^ op_b};
            4'd9:  alu_res = {8'b0, ~(op_a ^ op_b)};
            4'd10: alu_res = {15'b0, op_a == op_b};
            4'd11: alu_res = {15'b0, op_a > op_b};
            4'd12: alu_res = {8'b0, op_a >> 1};
            4'd13: alu_res = {7'b0, op_a, 1'b0};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            hi_pend_q <= 1'b0;
            hi_q      <= '0;
            for (int i = 0; i < NUM_OF_REGISTERS; i++) regs_q[i] <= '0;
        end else begin
            hi_pend_q <= 1'b0;
            if (frame_err_q) begin
                state_q <= S_IDLE;
            end else if (byte_valid_q) begin
                case (state_q)
                    S_IDLE: begin
                        case (rx_byte_q)
                            8'hAA:   state_q <= S_WR_ADDR;
                            8'hBB:   state_q <= S_RD_ADDR;
                            8'hCC:   state_q <= S_ALU_A;
                            8'hDD:   state_q <= S_ALU_FUNC;
                            default: state_q <= S_IDLE;
                        endcase
                    end
                    S_WR_ADDR: begin
                        addr_q  <= rx_byte_q[ADDRESS_WIDTH-1:0];
                        state_q <= S_WR_DATA;
                    end
                    S_WR_DATA: begin
                        regs_q[addr_q] <= rx_byte_q;
                        state_q        <= S_IDLE;
                    end
                    S_ALU_A: begin
                        regs_q[0] <= rx_byte_q;
                        state_q   <= S_ALU_B;
                    end
                    S_ALU_B: begin
                        regs_q[1] <= rx_byte_q;
                        state_q   <= S_ALU_FUNC;
                    end
                    S_ALU_FUNC: begin
                        // low byte is queued now, high byte on the next cycle
                        hi_q      <= alu_res[15:8];
                        hi_pend_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;  // S_RD_ADDR and unused codes
                endcase
            end
        end
    end

    logic                  enq_v;
    logic [DATA_WIDTH-1:0] enq_d;

    always_comb begin
        enq_v = 1'b0;
        enq_d = '0;
        if (hi_pend_q) begin
            enq_v = 1'b1;
            enq_d = hi_q;
        end else if (byte_valid_q && !frame_err_q && state_q == S_RD_ADDR) begin
            enq_v = 1'b1;
            enq_d = regs_q[rx_byte_q[ADDRESS_WIDTH-1:0]];
        end else if (byte_valid_q && state_q == S_ALU_FUNC) begin
            enq_v = 1'b1;
            enq_d = alu_res[7:0];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_WIDTH-1:0] fifo_q [TX_FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [FCW-1:0]        fcnt_q;
    logic                  push, pop;

    // ---------------- TX ----------------
    logic             tx_busy_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [3:0]       tx_bit_q;
    logic [10:0]      tx_frame_q;  // bit 0 is the bit currently on the line
    logic             tx_last;

    assign tx_last = tx_busy_q && tx_cnt_q == '0 && tx_bit_q == 4'd10;
    // pop while idle, or in the final stop-bit cycle so frames run back-to-back
    assign pop  = (fcnt_q != '0) && (!tx_busy_q || tx_last);
    assign push = enq_v && (fcnt_q != FCW'(TX_FIFO_DEPTH));

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            for (int i = 0; i < TX_FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= enq_d;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            fcnt_q <= fcnt_q + FCW'(push) - FCW'(pop);
        end
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= '1;
        end else if (pop) begin
            tx_busy_q  <= 1'b1;
            tx_cnt_q   <= BIT_LAST;
            tx_bit_q   <= '0;
            tx_frame_q <= {1'b1, ^fifo_q[rptr_q], fifo_q[rptr_q], 1'b0};
        end else if (tx_last) begin
            tx_busy_q  <= 1'b0;
            tx_frame_q <= '1;
        end else if (tx_busy_q) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - 1'b1;
            end else begin
                tx_cnt_q   <= BIT_LAST;
                tx_bit_q   <= tx_bit_q + 1'b1;
                tx_frame_q <= {1'b1, tx_frame_q[10:1]};
            end
        end
    end

    assign ser.S_DATA_OUT_TX = tx_busy_q ? tx_frame_q[0] : 1'b1;

endmodule

// File: tb/tb_top_sys.sv
module tb_top_sys;
    localparam int CPB = 16;

    logic REF_CLK = 1'b0;
    logic RST     = 1'b0;
    top_sys_if ser ();

    top_sys dut (.REF_CLK(REF_CLK), .RST(RST), .ser(ser));

    always #5 REF_CLK = ~REF_CLK;

    int nchk = 0;
    int nerr = 0;
    int tx_bad = 0;
    bit [7:0] rxq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Host-side transmitter: one frame, optionally with the parity bit inverted.
    task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0);
        logic [10:0] f;
        f = {1'b1, (^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ser.S_DATA_IN_RX = f[i];
            repeat (CPB) @(negedge REF_CLK);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int t;
        t = 0;
        while (rxq.size() == 0 && t < 3000) begin
            @(negedge REF_CLK);
            t++;
        end
        if (rxq.size() == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else                 chk(tag, rxq.pop_front(), exp);
    endtask

    // Host-side receiver: samples each bit of a TX frame at its middle.
    always begin
        @(negedge REF_CLK);
        if (RST && ser.S_DATA_OUT_TX == 1'b0) begin
            logic [9:0] bits;
            bit ab;
            ab = 1'b0;
            bits = '0;
            for (int k = 0; k < CPB / 2; k++) begin
                @(negedge REF_CLK);
                if (!RST) ab = 1'b1;
            end
            for (int i = 0; i < 10; i++) begin
                for (int k = 0; k < CPB; k++) begin
                    @(negedge REF_CLK);
                    if (!RST) ab = 1'b1;
                end
                bits[i] = ser.S_DATA_OUT_TX;
            end
            if (!ab) begin
                if ((^bits[8:0]) != 1'b0 || bits[9] != 1'b1) tx_bad++;
                rxq.push_back(bits[7:0]);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge REF_CLK);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        ser.S_DATA_IN_RX = 1'b1;
        RST = 1'b0;
        repeat (5) @(negedge REF_CLK);
        chk("rst_tx_line", ser.S_DATA_OUT_TX, 1'b1);
        RST = 1'b1;
        repeat (40) @(negedge REF_CLK);
        chk("idle_tx_line", ser.S_DATA_OUT_TX, 1'b1);

        // bad parity on the command byte: nothing written, 0x05/0x77 ignored
        send_byte(8'hAA, 1'b1);
        send_byte(8'h05);
        send_byte(8'h77);
        repeat (300) @(negedge REF_CLK);
        chk("perr_no_tx", rxq.size(), 0);
        send_byte(8'hBB); send_byte(8'h05);
        expect_byte("perr_read", 8'h00);

        // write then read back
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h77);
        send_byte(8'hBB); send_byte(8'h05);
        expect_byte("wr_rd_r5", 8'h77);
        repeat (300) @(negedge REF_CLK);
        chk("wr_rd_single", rxq.size(), 0);

        // subtract on registers: 0x77 - 0x82 = 0xFFF5
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h77);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h82);
        send_byte(8'hDD); send_byte(8'h01);
        expect_byte("sub_lo", 8'hF5);
        expect_byte("sub_hi", 8'hFF);

        // multiply with operands: 5*3
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h02);
        expect_byte("mul_lo", 8'h0F);
        expect_byte("mul_hi", 8'h00);
        send_byte(8'hBB); send_byte(8'h00);
        expect_byte("mul_r0", 8'h05);
        send_byte(8'hBB); send_byte(8'h01);
        expect_byte("mul_r1", 8'h03);

        // divide by zero, then invalid function code
        send_byte(8'hCC); send_byte(8'h09); send_byte(8'h00); send_byte(8'h03);
        expect_byte("div0_lo", 8'h00);
        expect_byte("div0_hi", 8'h00);
        send_byte(8'hDD); send_byte(8'h0E);
        expect_byte("inv_lo", 8'h00);
        expect_byte("inv_hi", 8'h00);

        // NAND 0xF0,0x3C = 0xCF; 0xF0>0x3C = 1; 0xF0<<1 = 0x1E0
        send_byte(8'hCC); send_byte(8'hF0); send_byte(8'h3C); send_byte(8'h06);
        expect_byte("nand_lo", 8'hCF);
        expect_byte("nand_hi", 8'h00);
        send_byte(8'hDD); send_byte(8'h0B);
        expect_byte("gt_lo", 8'h01);
        expect_byte("gt_hi", 8'h00);
        send_byte(8'hDD); send_byte(8'h0D);
        expect_byte("shl_lo", 8'hE0);
        expect_byte("shl_hi", 8'h01);

        // 2-cycle low glitch must not start a frame
        ser.S_DATA_IN_RX = 1'b0;
        repeat (2) @(negedge REF_CLK);
        ser.S_DATA_IN_RX = 1'b1;
        repeat (300) @(negedge REF_CLK);
        chk("glitch_no_tx", rxq.size(), 0);
        send_byte(8'hBB); send_byte(8'h00);
        expect_byte("glitch_r0", 8'hF0);

        // reset in the middle of a TX frame
        send_byte(8'hBB); send_byte(8'h00);
        begin
            int t;
            t = 0;
            while (ser.S_DATA_OUT_TX == 1'b1 && t < 3000) begin
                @(negedge REF_CLK);
                t++;
            end
            chk("rst_tx_started", ser.S_DATA_OUT_TX, 1'b0);
        end
        repeat (20) @(negedge REF_CLK);
        RST = 1'b0;
        #1;
        chk("rst_mid_tx_line", ser.S_DATA_OUT_TX, 1'b1);
        repeat (20) @(negedge REF_CLK);
        RST = 1'b1;
        repeat (300) @(negedge REF_CLK);
        rxq.delete();
        send_byte(8'hBB); send_byte(8'h00);
        expect_byte("rst_r0_clear", 8'h00);

        chk("tx_framing", tx_bad, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
